// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a dual-port SRAM: reads use port A, writes use port B.
// Each port has its own round-robin pointer, and a write takes priority over a read to the same address.
module sram_arbiter #(
  parameter int ADDR_WD = 9,
  parameter int DATA_WD = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,

  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic [ADDR_WD-1:0]   r0_addr,
  input  logic [DATA_WD-1:0]   r0_wdata,
  input  logic [DATA_WD/8-1:0] r0_mask,
  output logic                 r0_gnt,
  output logic                 r0_rvalid,
  output logic [DATA_WD-1:0]   r0_rdata,

  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic [ADDR_WD-1:0]   r1_addr,
  input  logic [DATA_WD-1:0]   r1_wdata,
  input  logic [DATA_WD/8-1:0] r1_mask,
  output logic                 r1_gnt,
  output logic                 r1_rvalid,
  output logic [DATA_WD-1:0]   r1_rdata,

  output logic                 sram_csb_a,
  output logic [ADDR_WD-1:0]   sram_addr_a,
  input  logic [DATA_WD-1:0]   sram_dout_a,

  output logic                 sram_csb_b,
  output logic                 sram_web_b,
  output logic [DATA_WD/8-1:0] sram_mask_b,
  output logic [ADDR_WD-1:0]   sram_addr_b,
  output logic [DATA_WD-1:0]   sram_din_b
);

  logic               armed;
  logic               rd_last;
  logic               wr_last;
  logic               rd_tag;
  logic [DATA_WD-1:0] rdata_q;

  logic               rd_el0, rd_el1, wr_el0, wr_el1;
  logic               rd_any, wr_any, rd_win, wr_win;
  logic               hazard, rd_go;
  logic [ADDR_WD-1:0] rd_win_addr, wr_win_addr;
  logic               ret;

  always_comb begin
    rd_el0 = armed & r0_req & ~r0_we & ~r0_gnt;
    rd_el1 = armed & r1_req & ~r1_we & ~r1_gnt;
    wr_el0 = armed & r0_req &  r0_we & ~r0_gnt;
    wr_el1 = armed & r1_req &  r1_we & ~r1_gnt;

    rd_any = rd_el0 | rd_el1;
    wr_any = wr_el0 | wr_el1;
    // When both are eligible, the pointer records the last winner, so the other requester wins.
    rd_win = (rd_el0 & rd_el1) ? ~rd_last : rd_el1;
    wr_win = (wr_el0 & wr_el1) ? ~wr_last : wr_el1;

    rd_win_addr = rd_win ? r1_addr : r0_addr;
    wr_win_addr = wr_win ? r1_addr : r0_addr;

    hazard = rd_any & wr_any & (rd_win_addr == wr_win_addr);
    rd_go  = rd_any & ~hazard;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      armed       <= 1'b0;
      rd_last     <= 1'b1;
      wr_last     <= 1'b1;
      rd_tag      <= 1'b0;
      r0_gnt      <= 1'b0;
      r1_gnt      <= 1'b0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
      rdata_q     <= '0;
      sram_csb_a  <= 1'b1;
      sram_addr_a <= '0;
      sram_csb_b  <= 1'b1;
      sram_web_b  <= 1'b1;
      sram_mask_b <= '0;
      sram_addr_b <= '0;
      sram_din_b  <= '0;
    end else begin
      armed  <= 1'b1;
      r0_gnt <= (rd_go & ~rd_win) | (wr_any & ~wr_win);
      r1_gnt <= (rd_go &  rd_win) | (wr_any &  wr_win);

      sram_csb_a <= ~rd_go;
      if (rd_go) begin
        sram_addr_a <= rd_win_addr;
        rd_last     <= rd_win;
        rd_tag      <= rd_win;
      end

      sram_csb_b <= ~wr_any;
      sram_web_b <= ~wr_any;
      if (wr_any) begin
        sram_addr_b <= wr_win_addr;
        sram_mask_b <= wr_win ? r1_mask  : r0_mask;
        sram_din_b  <= wr_win ? r1_wdata : r0_wdata;
        wr_last     <= wr_win;
      end

      // A read issued this cycle has its data on sram_dout_a next cycle.
      r0_rvalid <= ~sram_csb_a & ~rd_tag;
      r1_rvalid <= ~sram_csb_a &  rd_tag;

      if (ret) rdata_q <= sram_dout_a;
    end
  end

  // The SRAM output arrives in the return cycle itself, so it is passed through while rvalid is high.
  // The shared register holds the last returned word at all other times.
  assign ret      = r0_rvalid | r1_rvalid;
  assign r0_rdata = ret ? sram_dout_a : rdata_q;
  assign r1_rdata = ret ? sram_dout_a : rdata_q;

endmodule
